// File: rtl/x_multdiv_unit_if.sv
// Execute-stage bus between the D/X latch / X/M path and the multicycle mul/div engine.
interface x_multdiv_unit_if;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [4:0]  opcodeIn;
  logic [4:0]  aluopIn;
  logic [4:0]  rdIn;
  logic        stall;
  logic        resultValid;
  logic [31:0] result;
  logic [4:0]  rdOut;
  logic        exception;
  logic        busy;

  modport master (
    output operandA, operandB, opcodeIn, aluopIn, rdIn,
    input  stall, resultValid, result, rdOut, exception, busy
  );

  modport slave (
    input  operandA, operandB, opcodeIn, aluopIn, rdIn,
    output stall, resultValid, result, rdOut, exception, busy
  );
endinterface

// File: rtl/x_multdiv_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) engine for the execute stage.
// Optional MULTDIV_EARLY_OUT_EN lets a multiply finish once the remaining multiplier bits are zero.
module x_multdiv_unit #(
  parameter logic [4:0] ALU_OPCODE = 5'b00000,
  parameter logic [4:0] MUL_ALUOP  = 5'b00110,
  parameter logic [4:0] DIV_ALUOP  = 5'b00111
) (
  input  logic clock,
  input  logic reset,
  x_multdiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, nextState;

  logic        isMulOp, isDivOp, start, divByZero, lastIter, mulLast;
  logic [5:0]  count;
  logic        opDiv, signNeg, divOvf;
  logic [4:0]  rdHold;
  logic [63:0] acc, mcand;
  logic [31:0] mplr;
  logic [31:0] rem, quo, divisor;
  logic [31:0] resultReg, rdOutPad;
  logic [4:0]  rdOutReg;
  logic        exceptionReg;

  logic [63:0]        mulAddend, accNext, mcandNext;
  logic [31:0]        mplrNext;
  logic [32:0]        remShift, remDiff;
  logic               quoBit;
  logic [31:0]        remNext, quoNext;
  logic signed [63:0] prodNext;
  logic [31:0]        finalResult;
  logic               finalExc;

  function automatic logic [31:0] magnitude(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  function automatic logic signed [63:0] signedProduct(input logic [63:0] mag, input logic neg);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  // A product fits in 32 bits only if its upper 33 bits are a pure sign extension.
  function automatic logic mulOverflow(input logic [32:0] hi);
    return !((&hi) || (~|hi));
  endfunction

  function automatic logic [31:0] signedQuotient(input logic [31:0] q, input logic neg);
    return (neg && (q != 32'd0)) ? (~q + 32'd1) : q;
  endfunction

  assign isMulOp   = (bus.opcodeIn == ALU_OPCODE) && (bus.aluopIn == MUL_ALUOP);
  assign isDivOp   = (bus.opcodeIn == ALU_OPCODE) && (bus.aluopIn == DIV_ALUOP);
  assign start     = (state == IDLE) && (isMulOp || isDivOp);
  assign divByZero = isDivOp && (bus.operandB == 32'd0);

  // Shift-add multiply step: one multiplier bit per cycle.
  assign mulAddend = mplr[0] ? mcand : 64'd0;
  assign accNext   = acc + mulAddend;
  assign mplrNext  = mplr >> 1;
  assign mcandNext = mcand << 1;

  // Restoring divide step: remainder never exceeds the divisor magnitude, so 32 bits suffice.
  assign remShift = {rem, quo[31]};
  assign remDiff  = remShift - {1'b0, divisor};
  assign quoBit   = ~remDiff[32];
  assign remNext  = quoBit ? remDiff[31:0] : remShift[31:0];
  assign quoNext  = {quo[30:0], quoBit};

`ifdef MULTDIV_EARLY_OUT_EN
  assign mulLast = (mplrNext == 32'd0) || (count == 6'd31);
`else
  assign mulLast = (count == 6'd31);
`endif

  assign lastIter    = opDiv ? (count == 6'd31) : mulLast;
  assign prodNext    = signedProduct(accNext, signNeg);
  assign finalResult = opDiv ? signedQuotient(quoNext, signNeg) : prodNext[31:0];
  assign finalExc    = opDiv ? divOvf : mulOverflow(prodNext[63:31]);

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = divByZero ? DONE : BUSY;
      BUSY: if (lastIter) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= 6'd0;
      opDiv        <= 1'b0;
      signNeg      <= 1'b0;
      divOvf       <= 1'b0;
      rdHold       <= 5'd0;
      acc          <= 64'd0;
      mcand        <= 64'd0;
      mplr         <= 32'd0;
      rem          <= 32'd0;
      quo          <= 32'd0;
      divisor      <= 32'd0;
      resultReg    <= 32'd0;
      rdOutReg     <= 5'd0;
      exceptionReg <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            opDiv   <= isDivOp;
            rdHold  <= bus.rdIn;
            signNeg <= bus.operandA[31] ^ bus.operandB[31];
            divOvf  <= isDivOp && (bus.operandA == 32'h8000_0000) &&
                       (bus.operandB == 32'hFFFF_FFFF);
            count   <= 6'd0;
            acc     <= 64'd0;
            mcand   <= {32'd0, magnitude(bus.operandA)};
            mplr    <= magnitude(bus.operandB);
            rem     <= 32'd0;
            quo     <= magnitude(bus.operandA);
            divisor <= magnitude(bus.operandB);
            if (divByZero) begin
              resultReg    <= 32'd0;
              exceptionReg <= 1'b1;
              rdOutReg     <= bus.rdIn;
            end
          end
        end
        BUSY: begin
          count <= count + 6'd1;
          if (opDiv) begin
            rem <= remNext;
            quo <= quoNext;
          end else begin
            acc   <= accNext;
            mplr  <= mplrNext;
            mcand <= mcandNext;
          end
          if (lastIter) begin
            resultReg    <= finalResult;
            exceptionReg <= finalExc;
            rdOutReg     <= rdHold;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdOutPad        = {27'd0, rdOutReg};
  assign bus.stall       = start || (state == BUSY);
  assign bus.busy        = (state == BUSY);
  assign bus.resultValid = (state == DONE);
  assign bus.result      = resultReg;
  assign bus.rdOut       = rdOutPad[4:0];
  assign bus.exception   = exceptionReg;

endmodule
